multi_lane_ring_fifo: RTL and testbench
=======================================

Name: multi_lane_ring_fifo

Overview:
- Parametrised circular FIFO for lane-packed operand sets (DATA_OF_SET lanes × DATA_WIDTH bits) between the loaders and the convolution PE array.
- Successor to the single-configuration ring buffer. Adds power-of-two depth parametrisation, occupancy count, programmable almost-full/almost-empty thresholds, and first-word-fall-through (FWFT) read.
- Also adds synchronous flush and sticky overflow/underflow error flags.

Parameters:
- DATA_WIDTH, 32, bits per lane.
- DATA_OF_SET, 128, lanes per entry.
- DEPTH, 8, entries. Must be a power of two, ≥2; elaboration fatal otherwise.
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- flush, in, 1, synchronous clear of contents and pointers.
- wen, in, 1, push request.
- din, in, DATA_OF_SET×DATA_WIDTH, push data.
- ren, in, 1, pop request.
- dout, out, DATA_OF_SET×DATA_WIDTH, head entry (FWFT).
- full_flag, out, 1, count == DEPTH.
- empty_flag, out, 1, count == 0.
- almost_full, out, 1, count ≥ AF_LEVEL.
- almost_empty, out, 1, count ≤ AE_LEVEL.
- count, out, $clog2(DEPTH)+1, current occupancy.
- overflow_err, out, 1, sticky: push attempted while full.
- underflow_err, out, 1, sticky: pop attempted while empty.
- err_clr, in, 1, synchronous clear of both sticky error flags.

Behaviour:
- Pointers:
  - wptr and rptr are $clog2(DEPTH)+1 bits; the MSB is the wrap bit and the low bits index storage.
  - Wrap-around is natural binary rollover from DEPTH-1 to 0 with wrap-bit toggle.
- Flags:
  - empty when wptr == rptr.
  - full when the low bits are equal and the wrap bits differ.
  - count = wptr - rptr, modulo 2^(ADDR_W+1).
  - All flags and count are combinational from the registered pointers. No flag lags state.
- Accept rules:
  - push_ok = wen & !full_flag.
  - pop_ok = ren & !empty_flag.
  - Both are evaluated on pre-edge state.
- Simultaneous push and pop:
  - Not full and not empty: both accepted, count unchanged.
  - Full: pop accepted, push rejected, overflow_err set.
  - Empty: push accepted, pop rejected, underflow_err set.
- Storage:
  - On push_ok, mem[wptr low bits] ← din at the clock edge.
  - No reset on storage.
- FWFT read:
  - dout = mem[rptr low bits] combinationally.
  - dout is valid whenever empty_flag == 0; its value is don't-care when empty.
  - A pushed word appears on dout the cycle after the push edge, so push-to-dout latency is 1 cycle.
  - On pop_ok, the next entry presents after that edge.
- Error flags:
  - Set on rejected requests and held until err_clr or reset.
  - If err_clr and a new error occur in the same cycle, set wins.
- Flush:
  - wptr ← 0, rptr ← 0. Pushes and pops in the same cycle are ignored.
  - Error flags are unaffected.
  - Flush has priority over push and pop.
- Reset (rst_n low, asynchronous):
  - wptr = rptr = 0, so count = 0, empty_flag = 1, full_flag = 0, almost_empty = 1, almost_full = 0.
  - overflow_err = underflow_err = 0.
  - Reset mid-operation discards all contents. The first push after release lands in entry 0.
- Thresholds: AF_LEVEL and AE_LEVEL are compared against count. Values outside 0..DEPTH simply pin the corresponding flag.

Decomposition:
- Package conv_buf_pkg:
  - lane_set_t typedef: packed [DATA_OF_SET-1:0][DATA_WIDTH-1:0].
  - clog2-derived ADDR_W helper function.
  - Default width constants shared with the loaders.
- One sub-module, ring_ptr_ctrl:
  - Holds the pointers, accept logic, count, flags, and sticky errors.
  - The top level holds only the storage array and the dout mux, so the controller is reusable for narrower FIFOs.

Test Plan:
All scenarios use DEPTH=8, DATA_OF_SET=4, DATA_WIDTH=8, AF_LEVEL=6, AE_LEVEL=2.
- Reset, then push 0x01010101..0x08080808 (8 pushes):
  - almost_empty drops at count=3; almost_full rises at count=6; full_flag=1 and count=8 after the 8th push.
  - dout=0x01010101 from the cycle after the first push.
- Push a 9th word while full: rejected, overflow_err=1, count=8. Then pop 8:
  - dout sequence 0x01..0x08 in order, empty_flag=1, count=0.
- Pop while empty: underflow_err=1, pointers unchanged. Assert err_clr for one cycle: both errors return to 0.
- Wrap-around: fill with 5, pop 5, repeat 4 times with push and pop in the same cycle at count 3:
  - Data order preserved across the pointer wrap; count stays constant on simultaneous cycles.
- Full plus simultaneous push and pop: pop accepted, push rejected, overflow_err=1, count=7.
- Flush at count=5 together with wen=1: count=0 and empty_flag=1 next cycle. Then assert rst_n=0 asynchronously mid-stream: flags return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/conv_buf_pkg.sv
// Shared types and width defaults for the convolution operand buffers and loaders.
// Lane-set entries are DATA_OF_SET lanes of DATA_WIDTH bits, packed lane 0 in the LSBs.
package conv_buf_pkg;

   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_DATA_OF_SET = 128;
   localparam int DEF_DEPTH       = 8;

   typedef logic [DEF_DATA_OF_SET-1:0][DEF_DATA_WIDTH-1:0] lane_set_t;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/ring_ptr_ctrl.sv
// Pointer, occupancy, flag and sticky-error control for a power-of-two ring FIFO.
// Storage-agnostic, so it can also drive narrower FIFOs.
module ring_ptr_ctrl
   import conv_buf_pkg::*;
#(
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     wen,
   input  logic                     ren,
   input  logic                     err_clr,
   output logic                     push_ok,
   output logic [$clog2(DEPTH)-1:0] waddr,
   output logic [$clog2(DEPTH)-1:0] raddr,
   output logic                     full_flag,
   output logic                     empty_flag,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow_err,
   output logic                     underflow_err
);

   localparam int ADDR_W = addr_w(DEPTH);
   localparam int PTR_W  = ADDR_W + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "ring_ptr_ctrl: DEPTH must be a power of two >= 2");
   end

   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             pop_ok;
   int               count_i;

   // The MSB of each pointer is the wrap bit; the low bits address storage.
   assign empty_flag = (wptr_q == rptr_q);
   assign full_flag  = (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]) &&
                       (wptr_q[ADDR_W] != rptr_q[ADDR_W]);
   assign count      = wptr_q - rptr_q;
   assign count_i    = int'(count);

   // Signed compare so out-of-range thresholds simply pin the flag.
   assign almost_full  = (count_i >= AF_LEVEL);
   assign almost_empty = (count_i <= AE_LEVEL);

   assign push_ok = wen & ~full_flag & ~flush;
   assign pop_ok  = ren & ~empty_flag & ~flush;
   assign waddr   = wptr_q[ADDR_W-1:0];
   assign raddr   = rptr_q[ADDR_W-1:0];

   assign overflow_err  = ovf_q;
   assign underflow_err = udf_q;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (push_ok) wptr_d = wptr_q + 1'b1;
         if (pop_ok)  rptr_d = rptr_q + 1'b1;
      end
      // A new error in the same cycle as err_clr wins.
      ovf_d = (ovf_q & ~err_clr) | (wen & full_flag & ~flush);
      udf_d = (udf_q & ~err_clr) | (ren & empty_flag & ~flush);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
         udf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
         udf_q  <= udf_d;
      end
   end

endmodule

// File: rtl/multi_lane_ring_fifo.sv
// First-word-fall-through ring FIFO of lane-packed operand sets feeding the PE array.
// Holds only the storage and head-entry mux; all control lives in ring_ptr_ctrl.
module multi_lane_ring_fifo
   import conv_buf_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int DATA_OF_SET = DEF_DATA_OF_SET,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int AF_LEVEL    = DEPTH - 2,
   parameter int AE_LEVEL    = 2
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    flush,
   input  logic                                    wen,
   input  logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0]  din,
   input  logic                                    ren,
   output logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0]  dout,
   output logic                                    full_flag,
   output logic                                    empty_flag,
   output logic                                    almost_full,
   output logic                                    almost_empty,
   output logic [$clog2(DEPTH):0]                  count,
   output logic                                    overflow_err,
   output logic                                    underflow_err,
   input  logic                                    err_clr
);

   logic                                   push_ok;
   logic [$clog2(DEPTH)-1:0]               waddr;
   logic [$clog2(DEPTH)-1:0]               raddr;
   logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] mem_q [DEPTH];

   ring_ptr_ctrl #(
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL),
      .AE_LEVEL (AE_LEVEL)
   ) u_ctrl (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .wen           (wen),
      .ren           (ren),
      .err_clr       (err_clr),
      .push_ok       (push_ok),
      .waddr         (waddr),
      .raddr         (raddr),
      .full_flag     (full_flag),
      .empty_flag    (empty_flag),
      .almost_full   (almost_full),
      .almost_empty  (almost_empty),
      .count         (count),
      .overflow_err  (overflow_err),
      .underflow_err (underflow_err)
   );

   // Storage is deliberately not reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[waddr] <= din;
   end

   assign dout = mem_q[raddr];

endmodule

// File: tb/tb_multi_lane_ring_fifo.sv
// Scoreboard bench for multi_lane_ring_fifo at DEPTH=8, 4 lanes x 8 bits, AF=6, AE=2.
module tb_multi_lane_ring_fifo;

   localparam int DW    = 8;
   localparam int DOS   = 4;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 2;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     flush = 1'b0;
   logic                     wen = 1'b0;
   logic                     ren = 1'b0;
   logic                     err_clr = 1'b0;
   logic [DOS-1:0][DW-1:0]   din = '0;
   logic [DOS-1:0][DW-1:0]   dout;
   logic                     full_flag, empty_flag, almost_full, almost_empty;
   logic                     overflow_err, underflow_err;
   logic [3:0]               count;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] sb_q[$];
   logic        m_ovf = 1'b0;
   logic        m_udf = 1'b0;

   multi_lane_ring_fifo #(
      .DATA_WIDTH  (DW),
      .DATA_OF_SET (DOS),
      .DEPTH       (DEPTH),
      .AF_LEVEL    (AF),
      .AE_LEVEL    (AE)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .wen           (wen),
      .din           (din),
      .ren           (ren),
      .dout          (dout),
      .full_flag     (full_flag),
      .empty_flag    (empty_flag),
      .almost_full   (almost_full),
      .almost_empty  (almost_empty),
      .count         (count),
      .overflow_err  (overflow_err),
      .underflow_err (underflow_err),
      .err_clr       (err_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   task automatic check_state(input string tag);
      int c;
      c = sb_q.size();
      check({tag, ".count"}, 32'(count), 32'(c));
      check({tag, ".full"}, 32'(full_flag), 32'(c == DEPTH));
      check({tag, ".empty"}, 32'(empty_flag), 32'(c == 0));
      check({tag, ".afull"}, 32'(almost_full), 32'(c >= AF));
      check({tag, ".aempty"}, 32'(almost_empty), 32'(c <= AE));
      check({tag, ".ovf"}, 32'(overflow_err), 32'(m_ovf));
      check({tag, ".udf"}, 32'(underflow_err), 32'(m_udf));
   endtask

   // One clock: drive just after an edge, check head at negedge, update model and check after edge.
   task automatic step(input logic w, input logic r, input logic fl, input logic ec,
                       input logic [31:0] d, input string tag);
      logic push, pop, new_ovf, new_udf;
      int   c;
      wen = w; ren = r; flush = fl; err_clr = ec; din = d;
      @(negedge clk);
      c = sb_q.size();
      if (c > 0) check({tag, ".head"}, dout, sb_q[0]);
      push    = w && (c < DEPTH) && !fl;
      pop     = r && (c > 0) && !fl;
      new_ovf = w && (c == DEPTH) && !fl;
      new_udf = r && (c == 0) && !fl;
      @(posedge clk);
      #1;
      if (fl) sb_q.delete();
      else begin
         if (pop)  void'(sb_q.pop_front());
         if (push) sb_q.push_back(d);
      end
      m_ovf = (m_ovf && !ec) || new_ovf;
      m_udf = (m_udf && !ec) || new_udf;
      wen = 1'b0; ren = 1'b0; flush = 1'b0; err_clr = 1'b0;
      check_state(tag);
   endtask

   initial begin
      logic [31:0] d;
      repeat (2) @(posedge clk);
      #1;
      check_state("reset");
      rst_n = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, "idle");

      for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h01010101 * i, "fill");
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h09090909, "push_full");
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "drain");
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "pop_empty");
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, "err_clr");

      // Repeated fill/drain so both pointers wrap several times.
      for (int rep = 0; rep < 4; rep++) begin
         for (int k = 0; k < 3; k++) begin
            d = {$urandom_range(0, 255) > 0 ? 8'(rep) : 8'hEE, 8'(k), 16'($urandom)};
            step(1'b1, 1'b0, 1'b0, 1'b0, d, "wrap_push");
         end
         step(1'b1, 1'b1, 1'b0, 1'b0, $urandom, "wrap_both");
         for (int k = 0; k < 2; k++) step(1'b1, 1'b0, 1'b0, 1'b0, $urandom, "wrap_push");
         for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "wrap_pop");
      end

      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0, $urandom, "refill");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, "full_both");
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, "err_clr2");
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "to5");
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "to5");
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h12345678, "flush");

      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, $urandom, "pre_rst");
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, "err_set");
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "pre_rst_pop");
      // Assert reset between edges and check without any clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      sb_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      check_state("async_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'hA5C3_0F96, "post_rst_push");
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, "post_rst_pop");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
